rv32i_gpio_mmio: RTL and testbench
==================================

Name: rv32i_gpio_mmio

Overview:
Parametrised memory-mapped GPIO peripheral on the RV32I memTop I/O port, replacing the single-key/LED I/O block. It provides:
- synchronised, debounced key inputs with sticky press-event capture;
- synchronised switch inputs;
- a read/write LED register;
- per-key interrupt enables driving one level interrupt.

All register reads return through a registered read-data path.

Parameters:
ADDR_WIDTH, 15, width of io_addr (word address from memTop).
NUM_KEYS, 4, number of push-buttons (1..32).
NUM_LEDS, 10, number of LEDs (1..32).
NUM_SW, 10, number of slide switches (1..32).
DEBOUNCE_CYCLES, 50000, clocks a synchronised key level must be stable before it is accepted (>=2).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
key_n  input  NUM_KEYS  raw board buttons, active-low, asynchronous.
sw  input  NUM_SW  raw board switches, asynchronous.
io_we  input  1  write enable from memTop; 0 = read cycle.
io_addr  input  ADDR_WIDTH  word address from memTop; only io_addr[2:0] decoded.
io_wdata  input  32  write data from memTop.
led  output  NUM_LEDS  LED drive, active-high.
io_rdata  output  32  registered read data to memTop.
irq  output  1  level interrupt = |(KEY_EDGE & IRQ_EN), registered.

Behaviour:
Reset: clk and reset are as stated in Ports (clk system clock; reset synchronous, active-high). While reset is high:
- key sync flops = all 1 (released);
- debounced state = 0, debounce counters = 0;
- KEY_EDGE = 0, IRQ_EN = 0, led = 0, io_rdata = 0, irq = 0.

Register map (io_addr[2:0]); unused upper bits read 0:
- 0 KEY_STATE RO: debounced pressed level (1 = pressed).
- 1 KEY_EDGE RW1C: sticky press events. Writing 1 clears the bit; writing 0 leaves it unchanged.
- 2 LED RW: bits [NUM_LEDS-1:0].
- 3 SW RO: synchronised switch levels.
- 4 IRQ_EN RW: bits [NUM_KEYS-1:0].
- 5..7: read 0, writes ignored.

Synchronisers:
- key_n and sw each pass through a 2-flop synchroniser.
- The key path is inverted after synchronisation, giving active-high pressed.

Debounce, per key, independent counter of width clog2(DEBOUNCE_CYCLES):
- sync == stable: counter <= 0.
- sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
- otherwise: counter increments.
- A glitch shorter than DEBOUNCE_CYCLES clocks never changes stable.
- A clean press changes stable exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling key_n low.

Edge capture:
- A 0->1 transition of stable sets the KEY_EDGE bit. Release (1->0) sets nothing.
- Set and W1C clear on the same bit in the same cycle: set wins, bit stays 1.

Writes (io_we=1): take effect at the next rising edge. LED and IRQ_EN take the low bits of io_wdata; the remaining bits are ignored.

Reads (io_we=0):
- io_rdata <= selected register, zero-extended to 32 bits, so latency is 1 cycle.
- io_rdata holds its value during write cycles.
- Reads have no side effects; KEY_EDGE is not cleared by reading.

irq: registered and follows KEY_EDGE & IRQ_EN one cycle later.
- Enabling IRQ_EN while an edge is already pending asserts irq on the following cycle.

Reset mid-debounce: the counter is discarded. After reset releases, a key still held low is re-qualified from zero and then produces a press event.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4.)
1. Reset with key_n=4'b0000 held -> io_rdata=0, led=0, irq=0 during reset. After release, KEY_STATE reads 4'hF exactly 6 edges after the first low sample, and KEY_EDGE=4'hF.
2. key_n[1] low for 3 clocks then high (glitch) -> KEY_STATE and KEY_EDGE stay 0. Held low 10 clocks -> KEY_STATE=32'h2 and KEY_EDGE=32'h2; release -> KEY_STATE=0 and KEY_EDGE stays 32'h2.
3. Write addr 2 data 32'hFFFF_F2A5 -> led=10'h2A5 next cycle; read addr 2 -> io_rdata=32'h0000_02A5 one cycle after the read address.
4. KEY_EDGE=4'b0110, IRQ_EN written 4'b0100 -> irq=1 one cycle later. W1C write 32'h4 -> irq=0; KEY_EDGE reads 4'b0010.
5. W1C of bit 2 in the same cycle as a new key-2 press qualifies -> KEY_EDGE[2]=1 (set wins).
6. sw=10'h155 held -> read addr 3 returns 32'h155 (after 2-cycle sync). Reads of addr 5, 6, 7 return 0; writes to them change nothing.

Source files
------------

// File: rtl/rv32i_gpio_mmio.sv
// rv32i_gpio_mmio: memory-mapped GPIO for the memTop I/O port.
// Debounced keys with sticky press events, switches, LEDs and a key IRQ.
module rv32i_gpio_mmio #(
  parameter int ADDR_WIDTH      = 15,
  parameter int NUM_KEYS        = 4,
  parameter int NUM_LEDS        = 10,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   key_n,
  input  logic [NUM_SW-1:0]     sw,
  input  logic                  io_we,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [31:0]           io_wdata,
  output logic [NUM_LEDS-1:0]   led,
  output logic [31:0]           io_rdata,
  output logic                  irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] key_s1;
  logic [NUM_KEYS-1:0] key_s2;
  logic [NUM_KEYS-1:0] key_sync;
  logic [NUM_KEYS-1:0] key_stable;
  logic [NUM_KEYS-1:0] key_rise;
  logic [NUM_KEYS-1:0] key_evt;
  logic [NUM_KEYS-1:0] evt_clr;
  logic [NUM_KEYS-1:0] irq_en;
  logic [CW-1:0]       cnt [NUM_KEYS];
  logic [NUM_SW-1:0]   sw_s1;
  logic [NUM_SW-1:0]   sw_s2;
  logic [2:0]          reg_sel;
  logic                sel_state;
  logic                sel_evt;
  logic                sel_led;
  logic                sel_sw;
  logic                sel_ien;
  logic [31:0]         rd_mux;
  logic                unused_bits;

  assign key_sync = ~key_s2;
  assign reg_sel  = io_addr[2:0];
  assign sel_state = (reg_sel == 3'd0);
  assign sel_evt   = (reg_sel == 3'd1);
  assign sel_led   = (reg_sel == 3'd2);
  assign sel_sw    = (reg_sel == 3'd3);
  assign sel_ien   = (reg_sel == 3'd4);
  assign evt_clr = (io_we && sel_evt) ?
                   io_wdata[NUM_KEYS-1:0] : '0;
  assign unused_bits = ^{io_addr, io_wdata};

  // Two-flop synchronisers; keys idle released (high).
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // A key is about to be accepted as pressed this cycle.
  always_comb begin
    key_rise = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      key_rise[i] = key_sync[i] & ~key_stable[i] &
                    (cnt[i] == CNT_MAX);
  end

  // Per-key debounce: accept a new level after it has held long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_stable <= '0;
      for (int i = 0; i < NUM_KEYS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_sync[i] == key_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          key_stable[i] <= key_sync[i];
          cnt[i]        <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Read mux, zero-extended.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_state: rd_mux[NUM_KEYS-1:0] = key_stable;
      sel_evt:   rd_mux[NUM_KEYS-1:0] = key_evt;
      sel_led:   rd_mux[NUM_LEDS-1:0] = led;
      sel_sw:    rd_mux[NUM_SW-1:0]   = sw_s2;
      sel_ien:   rd_mux[NUM_KEYS-1:0] = irq_en;
      default:   rd_mux = '0;
    endcase
  end

  // Register file, sticky events (set beats clear), irq and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_evt  <= '0;
      irq_en   <= '0;
      led      <= '0;
      io_rdata <= '0;
      irq      <= 1'b0;
    end else begin
      key_evt <= (key_evt & ~evt_clr) | key_rise;
      irq     <= |(key_evt & irq_en);
      if (io_we && sel_led)
        led <= io_wdata[NUM_LEDS-1:0];
      if (io_we && sel_ien)
        irq_en <= io_wdata[NUM_KEYS-1:0];
      if (!io_we)
        io_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_rv32i_gpio_mmio.sv
// tb_rv32i_gpio_mmio: directed, table and random checks
// against a queue-based reference model.
module tb_rv32i_gpio_mmio;

  localparam int NK = 4;
  localparam int NL = 10;
  localparam int NS = 10;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NS-1:0] sw;
  logic          io_we;
  logic [14:0]   io_addr;
  logic [31:0]   io_wdata;
  logic [NL-1:0] led;
  logic [31:0]   io_rdata;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  rv32i_gpio_mmio #(
    .ADDR_WIDTH(15), .NUM_KEYS(NK), .NUM_LEDS(NL),
    .NUM_SW(NS), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw),
    .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .led(led), .io_rdata(io_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit [NK-1:0] m_s1, m_s2, m_stab, m_evt, m_ien;
  bit [NS-1:0] m_sw1, m_sw2;
  bit [NL-1:0] m_led;
  bit [31:0]   m_rd;
  bit          m_irq;
  bit          win [NK][$];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // One clock of behaviour: a key level is accepted once the last D
  // synchronised samples all disagree with the accepted level.
  function automatic void model_step();
    bit [NK-1:0] sync, rise, clr;
    bit [31:0]   rd;
    bit          all_diff;
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_sw1 = '0; m_sw2 = '0;
      m_stab = '0; m_evt = '0; m_ien = '0; m_led = '0;
      m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < NK; i++) win[i].delete();
      return;
    end
    sync = ~m_s2;
    rise = '0;
    rd = m_rd;
    if (!io_we) begin
      case (io_addr[2:0])
        3'd0: rd = 32'(m_stab);
        3'd1: rd = 32'(m_evt);
        3'd2: rd = 32'(m_led);
        3'd3: rd = 32'(m_sw2);
        3'd4: rd = 32'(m_ien);
        default: rd = 32'd0;
      endcase
    end
    m_irq = |(m_evt & m_ien);
    for (int i = 0; i < NK; i++) begin
      win[i].push_back(sync[i]);
      if (win[i].size() > D) void'(win[i].pop_front());
      all_diff = (win[i].size() == D);
      foreach (win[i][j])
        if (win[i][j] == m_stab[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_stab[i] = ~m_stab[i];
        rise[i] = m_stab[i];
        win[i].delete();
      end
    end
    clr = (io_we && io_addr[2:0] == 3'd1) ? io_wdata[NK-1:0] : '0;
    m_evt = (m_evt & ~clr) | rise;
    if (io_we && io_addr[2:0] == 3'd2) m_led = io_wdata[NL-1:0];
    if (io_we && io_addr[2:0] == 3'd4) m_ien = io_wdata[NK-1:0];
    m_s2 = m_s1; m_s1 = key_n;
    m_sw2 = m_sw1; m_sw1 = sw;
    m_rd = rd;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_rdata", io_rdata, m_rd);
    chk("model_led", 32'(led), 32'(m_led));
    chk("model_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic op(input logic we, input logic [2:0] a,
                    input logic [31:0] d);
    io_we = we; io_addr = 15'(a); io_wdata = d;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [9:0]  exp_led;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b0, 3'd3, 32'h0,         32'h155, 10'h2A5};
    vecs[1]  = '{1'b0, 3'd5, 32'h0,         32'h0,   10'h2A5};
    vecs[2]  = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0,   10'h2A5};
    vecs[3]  = '{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0,   10'h2A5};
    vecs[4]  = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0,   10'h2A5};
    vecs[5]  = '{1'b0, 3'd6, 32'h0,         32'h0,   10'h2A5};
    vecs[6]  = '{1'b0, 3'd7, 32'h0,         32'h0,   10'h2A5};
    vecs[7]  = '{1'b0, 3'd2, 32'h0,         32'h2A5, 10'h2A5};
    vecs[8]  = '{1'b0, 3'd4, 32'h0,         32'h4,   10'h2A5};
    vecs[9]  = '{1'b1, 3'd2, 32'h0000_0155, 32'h4,   10'h155};
    vecs[10] = '{1'b0, 3'd2, 32'h0,         32'h155, 10'h155};
    vecs[11] = '{1'b0, 3'd1, 32'h0,         32'h6,   10'h155};
    vecs[12] = '{1'b0, 3'd0, 32'h0,         32'h0,   10'h155};

    reset = 1'b1; key_n = '1; sw = '0;
    op(1'b0, 3'd0, 32'h0);

    // Reset with all keys held down.
    key_n = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rdata", io_rdata, 32'h0);
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
    end
    reset = 1'b0;
    ticks(6);
    chk("press_not_early", io_rdata, 32'h0);
    tick();
    chk("press_state", io_rdata, 32'hF);
    op(1'b0, 3'd1, 32'h0);
    tick();
    chk("press_evt", io_rdata, 32'hF);
    key_n = '1;
    ticks(10);
    op(1'b1, 3'd1, 32'hF);
    tick();
    op(1'b0, 3'd1, 32'h0);
    tick();
    chk("evt_cleared", io_rdata, 32'h0);

    // Glitch then clean press on key 1.
    key_n = 4'b1101;
    ticks(3);
    key_n = 4'b1111;
    ticks(8);
    op(1'b0, 3'd0, 32'h0);
    tick();
    chk("glitch_state", io_rdata, 32'h0);
    op(1'b0, 3'd1, 32'h0);
    tick();
    chk("glitch_evt", io_rdata, 32'h0);
    key_n = 4'b1101;
    ticks(10);
    op(1'b0, 3'd0, 32'h0);
    tick();
    chk("k1_state", io_rdata, 32'h2);
    op(1'b0, 3'd1, 32'h0);
    tick();
    chk("k1_evt", io_rdata, 32'h2);
    key_n = 4'b1111;
    ticks(10);
    op(1'b0, 3'd0, 32'h0);
    tick();
    chk("k1_rel_state", io_rdata, 32'h0);
    op(1'b0, 3'd1, 32'h0);
    tick();
    chk("k1_rel_evt", io_rdata, 32'h2);

    // LED write, read-data hold during write, readback.
    op(1'b1, 3'd2, 32'hFFFF_F2A5);
    tick();
    chk("led_write", 32'(led), 32'h2A5);
    chk("rdata_hold", io_rdata, 32'h2);
    op(1'b0, 3'd2, 32'h0);
    tick();
    chk("led_read", io_rdata, 32'h2A5);

    // Pending edge then enable irq; clear via W1C.
    key_n = 4'b1011;
    ticks(10);
    key_n = 4'b1111;
    ticks(10);
    op(1'b1, 3'd4, 32'h4);
    tick();
    op(1'b0, 3'd1, 32'h0);
    tick();
    chk("irq_on", 32'(irq), 32'h1);
    op(1'b1, 3'd1, 32'h4);
    tick();
    op(1'b0, 3'd1, 32'h0);
    tick();
    chk("irq_off", 32'(irq), 32'h0);
    chk("evt_w1c", io_rdata, 32'h2);

    // W1C lands on the same edge a new key-2 press qualifies.
    key_n = 4'b1011;
    ticks(5);
    op(1'b1, 3'd1, 32'h4);
    tick();
    op(1'b0, 3'd1, 32'h0);
    tick();
    chk("set_wins", io_rdata, 32'h6);
    key_n = 4'b1111;
    ticks(10);

    // Switches and register map table.
    sw = 10'h155;
    ticks(2);
    foreach (vecs[k]) begin
      op(vecs[k].we, vecs[k].addr, vecs[k].wdata);
      tick();
      chk($sformatf("vec%0d_rd", k), io_rdata, vecs[k].exp_rd);
      chk($sformatf("vec%0d_led", k), 32'(led), 32'(vecs[k].exp_led));
    end

    // Reset in the middle of a debounce; key still held afterwards.
    key_n = 4'b1110;
    op(1'b0, 3'd0, 32'h0);
    ticks(3);
    reset = 1'b1;
    tick();
    chk("mid_rst_led", 32'(led), 32'h0);
    reset = 1'b0;
    ticks(6);
    chk("requal_early", io_rdata, 32'h0);
    tick();
    chk("requal_state", io_rdata, 32'h1);
    op(1'b0, 3'd1, 32'h0);
    tick();
    chk("requal_evt", io_rdata, 32'h1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 14) == 0)
        key_n[$urandom_range(0, NK - 1)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0)
        sw = NS'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      op($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
         $urandom);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
